// File: rtl/branch_target_unit_if.sv
// rtl/branch_target_unit_if.sv - lookup/resolve bus between IF/EX and the branch target unit
// slave modport faces the branch target unit; master faces the pipeline (or a bench).
interface branch_target_unit_if #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) ();
   logic              lookup_valid;
   logic [ADDR_W-1:0] lookup_pc;
   logic              pred_valid;
   logic              pred_taken;
   logic [ADDR_W-1:0] pred_target;
   logic              resolve_valid;
   logic [ADDR_W-1:0] resolve_pc;
   logic [ADDR_W-1:0] resolve_imm;
   logic              resolve_taken;
   logic              resolve_pred_taken;
   logic [ADDR_W-1:0] resolve_pred_target;
   logic              target_valid;
   logic [ADDR_W-1:0] branch_target;
   logic              mispredict;
   logic [CNT_W-1:0]  mispredict_count;

   modport slave (
      input  lookup_valid, lookup_pc,
      output pred_valid, pred_taken, pred_target,
      input  resolve_valid, resolve_pc, resolve_imm, resolve_taken,
      input  resolve_pred_taken, resolve_pred_target,
      output target_valid, branch_target, mispredict, mispredict_count
   );

   modport master (
      output lookup_valid, lookup_pc,
      input  pred_valid, pred_taken, pred_target,
      output resolve_valid, resolve_pc, resolve_imm, resolve_taken,
      output resolve_pred_taken, resolve_pred_target,
      input  target_valid, branch_target, mispredict, mispredict_count
   );
endinterface

// File: rtl/branch_target_unit.sv
// rtl/branch_target_unit.sv - direct-mapped BTB with 2-bit counters and registered branch target adder
// Lookup reads the table combinationally and registers the result, so a same-cycle update is not seen.
module branch_target_unit #(
   parameter int ADDR_W  = 32,
   parameter int SHIFT   = 2,
   parameter int DEPTH   = 16,
   parameter int IDX_LSB = 2,
   parameter int CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   branch_target_unit_if.slave   bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int TAG_W = ADDR_W - IDX_LSB - IDX_W;
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(1) << SHIFT;

   logic              valid_q  [DEPTH];
   logic [TAG_W-1:0]  tag_q    [DEPTH];
   logic [ADDR_W-1:0] target_q [DEPTH];
   logic [1:0]        ctr_q    [DEPTH];

   logic [IDX_W-1:0]  l_idx;
   logic [TAG_W-1:0]  l_tag;
   logic              l_taken;
   logic [ADDR_W-1:0] l_target;

   logic [IDX_W-1:0]  r_idx;
   logic [TAG_W-1:0]  r_tag;
   logic              r_hit;
   logic [ADDR_W-1:0] r_target;
   logic              r_mis;

   always_comb begin
      l_idx    = bus.lookup_pc[IDX_LSB +: IDX_W];
      l_tag    = bus.lookup_pc[ADDR_W-1 -: TAG_W];
      l_taken  = valid_q[l_idx] && (tag_q[l_idx] == l_tag) && ctr_q[l_idx][1];
      l_target = l_taken ? target_q[l_idx] : bus.lookup_pc + STEP;
   end

   always_comb begin
      r_idx    = bus.resolve_pc[IDX_LSB +: IDX_W];
      r_tag    = bus.resolve_pc[ADDR_W-1 -: TAG_W];
      r_hit    = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
      r_target = bus.resolve_pc + (bus.resolve_imm << SHIFT);
      r_mis    = (bus.resolve_taken != bus.resolve_pred_taken) ||
                 (bus.resolve_taken && (bus.resolve_pred_target != r_target));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
         bus.pred_valid       <= 1'b0;
         bus.pred_taken       <= 1'b0;
         bus.pred_target      <= '0;
         bus.target_valid     <= 1'b0;
         bus.branch_target    <= '0;
         bus.mispredict       <= 1'b0;
         bus.mispredict_count <= '0;
      end else begin
         bus.pred_valid <= bus.lookup_valid;
         if (bus.lookup_valid) begin
            bus.pred_taken  <= l_taken;
            bus.pred_target <= l_target;
         end

         bus.target_valid <= bus.resolve_valid;
         bus.mispredict   <= bus.resolve_valid && r_mis;
         if (bus.resolve_valid) begin
            bus.branch_target <= r_target;
            if (r_mis && (bus.mispredict_count != {CNT_W{1'b1}}))
               bus.mispredict_count <= bus.mispredict_count + 1'b1;

            if (r_hit) begin
               if (bus.resolve_taken) begin
                  target_q[r_idx] <= r_target;
                  if (ctr_q[r_idx] != 2'b11)
                     ctr_q[r_idx] <= ctr_q[r_idx] + 2'b01;
               end else if (ctr_q[r_idx] != 2'b00) begin
                  ctr_q[r_idx] <= ctr_q[r_idx] - 2'b01;
               end
            end else if (bus.resolve_taken) begin
               // Allocation starts weakly taken so the very next lookup predicts taken.
               valid_q[r_idx]  <= 1'b1;
               tag_q[r_idx]    <= r_tag;
               target_q[r_idx] <= r_target;
               ctr_q[r_idx]    <= 2'b10;
            end
         end
      end
   end
endmodule

// File: tb/tb_branch_target_unit.sv
// tb/tb_branch_target_unit.sv - scoreboard bench for branch_target_unit
// Expectations come from an array-based BTB model; a negedge monitor pops and compares.
module tb_branch_target_unit;
   logic clk;
   logic reset;

   branch_target_unit_if #(.ADDR_W(32), .CNT_W(16)) bus ();

   branch_target_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        taken;
      logic [31:0] target;
   } pred_t;

   typedef struct packed {
      logic [31:0] target;
      logic        mis;
      logic [15:0] count;
   } res_t;

   pred_t pq[$];
   res_t  rq[$];

   int tests = 0;
   int fails = 0;

   bit          m_valid [16];
   logic [31:0] m_tag   [16];
   logic [31:0] m_tgt   [16];
   int          m_ctr   [16];
   int          m_count;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_clear();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 0;
         m_tag[i]   = 0;
         m_tgt[i]   = 0;
         m_ctr[i]   = 1;
      end
      m_count = 0;
   endfunction

   function automatic pred_t model_predict(input logic [31:0] pc);
      int idx;
      pred_t p;
      idx = (pc >> 2) % 16;
      if (m_valid[idx] && m_tag[idx] == (pc >> 6) && m_ctr[idx] >= 2) begin
         p.taken  = 1'b1;
         p.target = m_tgt[idx];
      end else begin
         p.taken  = 1'b0;
         p.target = pc + 32'd4;
      end
      return p;
   endfunction

   function automatic res_t model_resolve(input logic [31:0] pc, input logic [31:0] imm,
                                          input bit t, input bit pt, input logic [31:0] ptg);
      int idx;
      res_t r;
      logic [31:0] tgt;
      idx = (pc >> 2) % 16;
      tgt = pc + imm * 4;
      r.mis = (t != pt) || (t && ptg != tgt);
      if (r.mis && m_count < 65535) m_count++;
      if (m_valid[idx] && m_tag[idx] == (pc >> 6)) begin
         if (t) begin
            m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
            m_tgt[idx] = tgt;
         end else begin
            m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
         end
      end else if (t) begin
         m_valid[idx] = 1;
         m_tag[idx]   = pc >> 6;
         m_tgt[idx]   = tgt;
         m_ctr[idx]   = 2;
      end
      r.target = tgt;
      r.count  = 16'(m_count);
      return r;
   endfunction

   task automatic step(input bit rst, input bit lv, input logic [31:0] lpc,
                       input bit rv, input logic [31:0] rpc, input logic [31:0] imm,
                       input bit rt, input bit rpt, input logic [31:0] rptg);
      reset                   = rst;
      bus.lookup_valid        = lv;
      bus.lookup_pc           = lpc;
      bus.resolve_valid       = rv;
      bus.resolve_pc          = rpc;
      bus.resolve_imm         = imm;
      bus.resolve_taken       = rt;
      bus.resolve_pred_taken  = rpt;
      bus.resolve_pred_target = rptg;
      if (rst) begin
         model_clear();
      end else begin
         // lookup is modelled before the update: read-before-write
         if (lv) pq.push_back(model_predict(lpc));
         if (rv) rq.push_back(model_resolve(rpc, imm, rt, rpt, rptg));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic lookup(input logic [31:0] pc);
      step(0, 1, pc, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic resolve(input logic [31:0] pc, input logic [31:0] imm, input bit t,
                          input bit pt, input logic [31:0] ptg);
      step(0, 0, 0, 1, pc, imm, t, pt, ptg);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic check_reset_state();
      chk("rst_pred_valid", 32'(bus.pred_valid), 0);
      chk("rst_pred_taken", 32'(bus.pred_taken), 0);
      chk("rst_pred_target", bus.pred_target, 0);
      chk("rst_target_valid", 32'(bus.target_valid), 0);
      chk("rst_branch_target", bus.branch_target, 0);
      chk("rst_mispredict", 32'(bus.mispredict), 0);
      chk("rst_count", 32'(bus.mispredict_count), 0);
   endtask

   always @(negedge clk) begin
      if (bus.pred_valid) begin
         if (pq.size() == 0) begin
            chk("pred_unexpected", 32'(bus.pred_valid), 0);
         end else begin
            pred_t p;
            p = pq.pop_front();
            chk("pred_taken", 32'(bus.pred_taken), 32'(p.taken));
            chk("pred_target", bus.pred_target, p.target);
         end
      end
      if (bus.target_valid) begin
         if (rq.size() == 0) begin
            chk("target_unexpected", 32'(bus.target_valid), 0);
         end else begin
            res_t r;
            r = rq.pop_front();
            chk("branch_target", bus.branch_target, r.target);
            chk("mispredict", 32'(bus.mispredict), 32'(r.mis));
            chk("mispredict_count", 32'(bus.mispredict_count), 32'(r.count));
         end
      end else if (bus.mispredict) begin
         chk("mispredict_idle", 32'(bus.mispredict), 0);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      model_clear();
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      check_reset_state();

      lookup(32'h100);
      resolve(32'h100, 32'h10, 1, 0, 32'h104);
      lookup(32'h100);
      // counter walk: 10 -> 01 -> 00 -> 01 -> 10
      resolve(32'h100, 32'h10, 0, 1, 32'h140);
      resolve(32'h100, 32'h10, 0, 0, 32'h104);
      lookup(32'h100);
      resolve(32'h100, 32'h10, 1, 0, 32'h104);
      lookup(32'h100);
      resolve(32'h100, 32'h10, 1, 0, 32'h104);
      lookup(32'h100);
      // alias at index 0 with a different tag
      resolve(32'h140, 32'h4, 1, 0, 32'h144);
      lookup(32'h100);
      lookup(32'h140);
      resolve(32'h4, 32'hFFFF_FFFE, 1, 1, 32'hFFFF_FFFC);
      resolve(32'hFFFF_FFFC, 32'h1, 1, 1, 32'h0);
      step(0, 1, 32'h200, 1, 32'h200, 32'h8, 1, 0, 32'h204);
      lookup(32'h200);
      step(0, 1, 32'h200, 1, 32'h200, 32'h8, 1, 1, 32'h220);
      step(1, 1, 32'h200, 1, 32'h300, 32'h8, 1, 0, 32'h0);
      check_reset_state();
      lookup(32'h200);
      idle();

      for (int i = 0; i < 3000; i++) begin
         logic [31:0] lpc, rpc, imm, ptg;
         bit lv, rv, rt, pt, rst;
         pred_t mp;
         lpc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
         rpc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
         if ($urandom_range(0, 9) == 0) rpc = $urandom;
         if ($urandom_range(0, 9) == 0) lpc = $urandom;
         imm = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 31)) - 32'd16;
         lv  = $urandom_range(0, 1);
         rv  = $urandom_range(0, 2) != 0;
         rt  = $urandom_range(0, 2) != 0;
         mp  = model_predict(rpc);
         pt  = ($urandom_range(0, 3) == 0) ? bit'($urandom_range(0, 1)) : mp.taken;
         ptg = ($urandom_range(0, 5) == 0) ? $urandom : mp.target;
         rst = ($urandom_range(0, 499) == 0);
         step(rst, lv, lpc, rv, rpc, imm, rt, pt, ptg);
         if (rst) check_reset_state();
      end

      idle();
      idle();
      chk("pred_queue_empty", 32'(pq.size()), 0);
      chk("res_queue_empty", 32'(rq.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
